// File: rtl/fifo_word_packer.sv
// Read-side consumer of an async FIFO: drains bytes and packs them little-endian
// into BYTES-wide words on a valid/ready output, with flush and idle-timeout support.
module fifo_word_packer #(
    parameter int DATA_W  = 8,
    parameter int BYTES   = 4,
    parameter int IDLE_TO = 32
) (
    input  logic                      r_clk,
    input  logic                      rst,
    input  logic                      empty,
    input  logic [DATA_W-1:0]         d_out,
    output logic                      rd_en,
    input  logic                      flush,
    output logic [DATA_W*BYTES-1:0]   m_data,
    output logic [BYTES-1:0]          m_keep,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [15:0]               word_cnt
);

    localparam int OUT_W = DATA_W * BYTES;
    localparam int CW    = $clog2(BYTES + 1);
    localparam int IW    = $clog2(IDLE_TO + 2);

    logic [OUT_W-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic             rd_pend_r;
    logic             flush_req_r;
    logic [IW-1:0]    idle_r;

    logic             out_free_s;
    logic             full_s;
    logic             idle_inc_s;
    logic             idle_hit_s;
    logic             req_s;
    logic             emit_s;
    logic             req_done_s;
    logic [CW-1:0]    cnt_eff_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic [OUT_W-1:0] acc_nxt_s;
    logic [BYTES-1:0] keep_s;

    // Emission and flush-request control; an emitting cycle frees the accumulator immediately.
    always_comb begin
        out_free_s = !m_valid | m_ready;
        full_s     = (cnt_r == CW'(BYTES));
        idle_inc_s = (cnt_r != {CW{1'b0}}) & !rd_pend_r;
        if (IDLE_TO != 0) begin
            idle_hit_s = idle_inc_s & (idle_r == IW'(IDLE_TO - 1));
        end else begin
            idle_hit_s = 1'b0;
        end
        req_s      = flush_req_r | idle_hit_s;
        req_done_s = req_s & !rd_pend_r & out_free_s;
        emit_s     = out_free_s & (full_s | (req_s & !rd_pend_r & (cnt_r != {CW{1'b0}})));
        if (emit_s) begin
            cnt_eff_s = {CW{1'b0}};
        end else begin
            cnt_eff_s = cnt_r;
        end
    end

    // FIFO read strobe: never overcommit the accumulator, counting the read in flight.
    always_comb begin
        rd_en = !rst & !empty & !req_s &
                (({1'b0, cnt_eff_s} + {{CW{1'b0}}, rd_pend_r}) < (CW + 1)'(BYTES));
    end

    // Accumulator update: a captured byte lands in lane cnt_eff (lane 0 after an emit).
    always_comb begin
        if (emit_s) begin
            acc_nxt_s = {OUT_W{1'b0}};
        end else begin
            acc_nxt_s = acc_r;
        end
        if (rd_pend_r) begin
            acc_nxt_s[DATA_W*cnt_eff_s +: DATA_W] = d_out;
            cnt_nxt_s = cnt_eff_s + CW'(1);
        end else begin
            cnt_nxt_s = cnt_eff_s;
        end
    end

    // Valid-lane mask for the word being emitted.
    always_comb begin
        keep_s = {BYTES{1'b0}};
        for (int k = 0; k < BYTES; k++) begin
            if (CW'(k) < cnt_r) begin
                keep_s[k] = 1'b1;
            end else begin
                keep_s[k] = 1'b0;
            end
        end
    end

    // State registers: accumulator, output register, flush request, idle timer, word count.
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            acc_r       <= {OUT_W{1'b0}};
            cnt_r       <= {CW{1'b0}};
            rd_pend_r   <= 1'b0;
            flush_req_r <= 1'b0;
            idle_r      <= {IW{1'b0}};
            m_data      <= {OUT_W{1'b0}};
            m_keep      <= {BYTES{1'b0}};
            m_valid     <= 1'b0;
            word_cnt    <= 16'd0;
        end else begin
            rd_pend_r <= rd_en;
            acc_r     <= acc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            word_cnt  <= word_cnt + {15'd0, m_valid & m_ready};

            if (emit_s) begin
                m_data  <= acc_r;
                m_keep  <= keep_s;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end else begin
                m_valid <= m_valid;
            end

            if (req_done_s) begin
                flush_req_r <= flush;
            end else if (flush | idle_hit_s) begin
                flush_req_r <= 1'b1;
            end else begin
                flush_req_r <= flush_req_r;
            end

            if (rd_pend_r | emit_s | (cnt_r == {CW{1'b0}})) begin
                idle_r <= {IW{1'b0}};
            end else if ((IDLE_TO != 0) && idle_inc_s && (idle_r != IW'(IDLE_TO))) begin
                idle_r <= idle_r + IW'(1);
            end else begin
                idle_r <= idle_r;
            end
        end
    end

endmodule
